uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, transmit FIFO depth in bytes (power of 2, minimum 2).
REQ-002 SHALL have parameter PARITY_EN, default 1, where 1 inserts an even-parity bit after the data bits.
REQ-003 SHALL have parameter IDLE_BITS, default 0, giving extra high bit-times inserted after each stop bit.
REQ-004 rx_clk  input  1  bit clock; one line bit per rising edge; all logic on this edge.
REQ-005 rst_n  input  1  reset: synchronous, active-low, sampled on rx_clk.
REQ-006 tx_enabled  input  1  permits starting a new frame.
REQ-007 tx_data  input  8  byte to enqueue.
REQ-008 tx_valid  input  1  tx_data valid this cycle.
REQ-009 tx_ready  output  1  FIFO can accept a byte (not full).
REQ-010 tx_out  output  1  serial line, registered, idle high.
REQ-011 tx_busy  output  1  frame or gap in progress.
REQ-012 tx_done  output  1  one-cycle pulse at frame completion.
REQ-013 fifo_level  output  log2(DEPTH)+1  bytes queued, range 0..DEPTH.

Function
REQ-014 SHALL push tx_data on an edge where tx_valid && tx_ready; tx_ready SHALL equal (fifo_level != DEPTH).
REQ-015 SHALL ignore tx_valid while tx_ready is low; the byte is dropped, with no state change.
REQ-016 SHALL pop bytes in FIFO order; a push and a pop on the same edge SHALL leave fifo_level unchanged.
REQ-017 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP and GAP.
REQ-018 IDLE: SHALL hold tx_out=1; on an edge with fifo_level!=0 && tx_enabled, SHALL pop into the shift register, set tx_out<=0 and go to START.
REQ-019 SHALL drive tx_out low in the cycle after a push into an empty, idle, enabled block (latency 1 edge).
REQ-020 START: SHALL hold tx_out=0 for one bit-time, then go to DATA.
REQ-021 DATA: SHALL shift out 8 bits, LSB first, one per edge, counted by a 3-bit counter.
REQ-022 After bit 7, SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-023 PARITY: SHALL drive tx_out = XOR of the 8 data bits for one bit-time.
REQ-024 STOP: SHALL drive tx_out=1 for one bit-time.
REQ-025 tx_done SHALL be 1 in the cycle following the STOP bit-time.
REQ-026 After STOP, SHALL go to GAP if IDLE_BITS>0 (tx_out=1 for IDLE_BITS bit-times), else to IDLE.
REQ-027 With IDLE_BITS=0 and data queued, SHALL place the next start bit immediately after the stop bit.
REQ-028 Frame length SHALL be 11 bit-times with parity, 10 without.
REQ-029 tx_busy SHALL be 1 in every state except IDLE.
REQ-030 tx_enabled falling mid-frame SHALL NOT abort the frame; the frame completes and no further pop occurs while tx_enabled is low.
REQ-031 Pushes during transmission SHALL be accepted normally.
REQ-032 The line format SHALL be decodable by the team's one-bit-per-clock UART receiver: falling-edge start, 8 data bits LSB first, even parity, stop bit high.

Reset
REQ-033 While rst_n=0 at an edge: tx_out<=1, tx_done<=0, state<=IDLE, FIFO flushed (fifo_level=0, tx_ready=1), bit counter cleared.
REQ-034 While rst_n=0, tx_busy SHALL be 0 and pushes SHALL be ignored.
REQ-035 Reset mid-frame SHALL truncate the frame; the line is high from the next edge.

Verification
REQ-036 Push 0xA5 (PARITY_EN=1) -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 on consecutive edges; tx_done pulses once.
REQ-037 Push 0x01 -> sequence 0,1,0,0,0,0,0,0,0,1,1 (parity bit 1).
REQ-038 Push 5 bytes on 5 consecutive cycles while idle -> bytes 1-5 accepted (byte 1 popped at the first edge); a 6th push in the next cycle is dropped with tx_ready=0; 5 back-to-back frames in 55 cycles; fifo_level returns to 0.
REQ-039 Assert rst_n=0 during data bit 3 -> next edge tx_out=1, tx_busy=0, fifo_level=0, no tx_done.
REQ-040 tx_enabled=0 with 2 bytes queued -> tx_out stays 1 and fifo_level=2; raise tx_enabled -> tx_out=0 at the next edge.
REQ-041 Loop tx_out into the team's UART receiver on the same rx_clk; send 0x00, 0xFF, 0x5A -> receiver data_out matches each byte and rx_ready pulses once per frame.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter emitting one line bit per rx_clk edge.
// Frame: start (0), 8 data bits LSB first, optional even parity, stop (1),
// then IDLE_BITS extra high bit-times before the next frame may start.
//
// Ports
//   rx_clk      in   clock; one line bit per rising edge
//   rst_n       in   synchronous active-low reset
//   tx_enabled  in   permits starting a new frame
//   tx_data     in   byte to enqueue
//   tx_valid    in   tx_data valid this cycle
//   tx_ready    out  FIFO not full
//   tx_out      out  registered serial line, idle high
//   tx_busy     out  frame or gap in progress
//   tx_done     out  one-cycle pulse after the stop bit-time
//   fifo_level  out  bytes queued, 0..DEPTH
module uart_tx #(
  parameter int DEPTH     = 4,
  parameter int PARITY_EN = 1,
  parameter int IDLE_BITS = 0
) (
  input  logic                     rx_clk,
  input  logic                     rst_n,
  input  logic                     tx_enabled,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int GW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = (IDLE_BITS > 0) ? GW'(IDLE_BITS - 1) : '0;
  localparam logic [PW:0]   FULL     = (PW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   level_q;

  state_t        state_q;
  logic [2:0]    cnt_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    byte_q;
  logic          tx_out_q;
  logic          done_q;

  logic          push;
  logic          pop;
  logic          slot_free;

  // slot_free marks the edge at which a new start bit may go on the line:
  // while idle, at the end of the stop bit (no gap), or at the last gap bit.
  always_comb begin
    push      = tx_valid && tx_ready;
    slot_free = (state_q == IDLE)
             || ((state_q == STOP) && (IDLE_BITS == 0))
             || ((state_q == GAP) && (gap_q == GAP_LAST));
    pop       = slot_free && tx_enabled && (level_q != '0);
  end

  // FIFO storage carries no reset; only pointers and level are cleared.
  always_ff @(posedge rx_clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (PW + 1)'(1);
        2'b01:   level_q <= level_q - (PW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // state_q names the bit currently driven on tx_out.
  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      gap_q    <= '0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        START: begin
          tx_out_q <= byte_q[0];
          cnt_q    <= 3'd0;
          state_q  <= DATA;
        end
        DATA: begin
          if (cnt_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              tx_out_q <= ^byte_q;
              state_q  <= PARITY;
            end else begin
              tx_out_q <= 1'b1;
              state_q  <= STOP;
            end
          end else begin
            tx_out_q <= byte_q[cnt_q + 3'd1];
            cnt_q    <= cnt_q + 3'd1;
          end
        end
        PARITY: begin
          tx_out_q <= 1'b1;
          state_q  <= STOP;
        end
        STOP: begin
          done_q <= 1'b1;
          if (IDLE_BITS > 0) begin
            tx_out_q <= 1'b1;
            gap_q    <= '0;
            state_q  <= GAP;
          end
        end
        GAP: begin
          if (gap_q != GAP_LAST) gap_q <= gap_q + GW'(1);
        end
        default: ;
      endcase
      // Launching overrides the per-state defaults so frames can run back to back.
      if (slot_free) begin
        if (pop) begin
          byte_q   <= mem_q[rd_q];
          tx_out_q <= 1'b0;
          state_q  <= START;
        end else begin
          tx_out_q <= 1'b1;
          state_q  <= IDLE;
        end
      end
    end
  end

  assign tx_ready   = (level_q != FULL);
  assign tx_out     = tx_out_q;
  assign tx_busy    = rst_n && (state_q != IDLE);
  assign tx_done    = done_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  logic       rst_n, tx_enabled, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_out, tx_busy, tx_done;
  logic [2:0] fifo_level;

  logic       en2, v2;
  logic [7:0] d2;
  logic       ready2, out2, busy2, done2;
  logic [2:0] level2;

  uart_tx #(.DEPTH(4), .PARITY_EN(1), .IDLE_BITS(0)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .tx_enabled(tx_enabled), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_level(fifo_level)
  );

  uart_tx #(.DEPTH(4), .PARITY_EN(0), .IDLE_BITS(2)) dut2 (
    .rx_clk(rx_clk), .rst_n(rst_n), .tx_enabled(en2), .tx_data(d2),
    .tx_valid(v2), .tx_ready(ready2), .tx_out(out2), .tx_busy(busy2),
    .tx_done(done2), .fifo_level(level2)
  );

  int checks = 0;
  int errors = 0;

  // Reference one-bit-per-clock receiver: falling-edge start, 8 bits LSB first,
  // even parity, stop high. Each good frame is one rx_ready event (queue push).
  logic [7:0] rx_q [$];
  int         rx_st  = 0;
  int         rx_bad = 0;
  logic [7:0] rx_sh;
  logic       rx_par;
  logic       prev_q;
  int         done_cnt = 0;

  always @(posedge rx_clk) begin
    prev_q <= tx_out;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (rst_n !== 1'b1) begin
      rx_st <= 0;
    end else if (rx_st == 0) begin
      if (prev_q === 1'b1 && tx_out === 1'b0) rx_st <= 1;
    end else if (rx_st <= 8) begin
      rx_sh <= {tx_out, rx_sh[7:1]};
      rx_st <= rx_st + 1;
    end else if (rx_st == 9) begin
      rx_par <= tx_out;
      rx_st  <= 10;
    end else begin
      rx_st <= 0;
      if (tx_out === 1'b1 && rx_par === ^rx_sh) rx_q.push_back(rx_sh);
      else rx_bad <= rx_bad + 1;
    end
  end

  task automatic tick;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_check(input logic [7:0] b, input logic [10:0] seq, input string tag);
    tx_valid = 1'b1;
    tx_data  = b;
    tick;
    tx_valid = 1'b0;
    check({tag, "_level_after_push"}, fifo_level, 3'd1);
    check({tag, "_line_before_pop"}, tx_out, 1'b1);
    for (int i = 10; i >= 0; i--) begin
      tick;
      check($sformatf("%s_bit%0d", tag, 10 - i), tx_out, seq[i]);
      check($sformatf("%s_nodone%0d", tag, 10 - i), tx_done, 1'b0);
    end
    check({tag, "_busy_in_stop"}, tx_busy, 1'b1);
    tick;
    check({tag, "_done_pulse"}, tx_done, 1'b1);
    check({tag, "_idle_busy"}, tx_busy, 1'b0);
    check({tag, "_idle_line"}, tx_out, 1'b1);
    tick;
    check({tag, "_done_cleared"}, tx_done, 1'b0);
  endtask

  initial begin
    logic [10:0] seq_a5;
    logic [10:0] seq_01;
    logic [12:0] seq2;
    int          n;
    int          seen;
    int          base;
    int          d0;

    seq_a5 = 11'b01010010101;
    seq_01 = 11'b01000000011;
    seq2   = 13'b0101001011110;

    rst_n = 1'b0; tx_enabled = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    en2 = 1'b1; v2 = 1'b0; d2 = 8'h00;

    // Reset state
    repeat (2) tick;
    check("rst_line", tx_out, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_line2", out2, 1'b1);
    rst_n = 1'b1;
    tick;

    // Single frames
    frame_check(8'hA5, seq_a5, "a5");
    frame_check(8'h01, seq_01, "x01");

    // Five pushes back to back, sixth dropped while full
    base = rx_q.size();
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(8'h11 * (i + 1));
      check($sformatf("burst_ready%0d", i), tx_ready, 1'b1);
      tick;
    end
    tx_data = 8'h66;
    check("full_ready", tx_ready, 1'b0);
    check("full_level", fifo_level, 3'd4);
    tick;
    tx_valid = 1'b0;
    check("drop_level", fifo_level, 3'd4);
    n = 0; seen = 0;
    while (seen < 5 && n < 200) begin
      tick; n++;
      if (tx_done === 1'b1) seen++;
    end
    check("burst_frames", seen, 5);
    check("burst_timing", n, 51);
    check("burst_level0", fifo_level, 3'd0);
    repeat (3) tick;
    check("burst_rx_count", rx_q.size(), base + 5);
    for (int i = 0; i < 5; i++)
      if (rx_q.size() > base + i)
        check($sformatf("burst_rx%0d", i), rx_q[base + i], 8'(8'h11 * (i + 1)));

    // Reset during data bit 3
    base = rx_q.size();
    tx_valid = 1'b1; tx_data = 8'h3C;
    tick;
    tx_valid = 1'b0;
    repeat (5) tick;
    check("mid_bit3", tx_out, 1'b1);
    check("mid_busy", tx_busy, 1'b1);
    d0 = done_cnt;
    rst_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h99;
    #1;
    check("rst_busy_comb", tx_busy, 1'b0);
    tick;
    check("trunc_line", tx_out, 1'b1);
    check("trunc_busy", tx_busy, 1'b0);
    check("trunc_level", fifo_level, 3'd0);
    check("trunc_done", tx_done, 1'b0);
    check("trunc_ready", tx_ready, 1'b1);
    tick;
    check("rst_push_ignored", fifo_level, 3'd0);
    rst_n = 1'b1; tx_valid = 1'b0;
    repeat (13) tick;
    check("trunc_line_after", tx_out, 1'b1);
    check("trunc_no_done", done_cnt, d0);
    check("trunc_no_rx", rx_q.size(), base);

    // Enable gating
    tx_enabled = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h81;
    tick;
    tx_data = 8'h7E;
    tick;
    tx_valid = 1'b0;
    repeat (3) tick;
    check("dis_line", tx_out, 1'b1);
    check("dis_level", fifo_level, 3'd2);
    check("dis_busy", tx_busy, 1'b0);
    tx_enabled = 1'b1;
    tick;
    check("en_start", tx_out, 1'b0);
    check("en_level", fifo_level, 3'd1);
    repeat (2) tick;
    tx_enabled = 1'b0;
    n = 0;
    while (tx_done !== 1'b1 && n < 40) begin tick; n++; end
    check("dis_mid_completes", n, 9);
    repeat (3) tick;
    check("dis_no_pop_level", fifo_level, 3'd1);
    check("dis_no_pop_line", tx_out, 1'b1);
    check("dis_no_pop_busy", tx_busy, 1'b0);
    tx_enabled = 1'b1;
    n = 0;
    while (tx_done !== 1'b1 && n < 40) begin tick; n++; end
    check("reen_done", tx_done, 1'b1);
    tick;
    check("en_rx81", rx_q[rx_q.size() - 2], 8'h81);
    check("en_rx7e", rx_q[rx_q.size() - 1], 8'h7E);

    // Loopback through the receiver model
    base = rx_q.size();
    tx_valid = 1'b1; tx_data = 8'h00; tick;
    tx_data = 8'hFF; tick;
    tx_data = 8'h5A; tick;
    tx_valid = 1'b0;
    n = 0; seen = 0;
    while (seen < 3 && n < 100) begin
      tick; n++;
      if (tx_done === 1'b1) seen++;
    end
    check("loop_frames", seen, 3);
    repeat (2) tick;
    check("loop_rx_count", rx_q.size(), base + 3);
    if (rx_q.size() >= base + 3) begin
      check("loop_rx00", rx_q[base], 8'h00);
      check("loop_rxff", rx_q[base + 1], 8'hFF);
      check("loop_rx5a", rx_q[base + 2], 8'h5A);
    end
    check("loop_rx_bad", rx_bad, 0);

    // No parity, two gap bits: 10-bit frame, gap, next start
    v2 = 1'b1; d2 = 8'hA5; tick;
    d2 = 8'h00; tick;
    v2 = 1'b0;
    check("np_bit1", out2, seq2[12]);
    for (int k = 2; k <= 13; k++) begin
      tick;
      check($sformatf("np_bit%0d", k), out2, seq2[13 - k]);
      if (k == 11) check("np_done", done2, 1'b1);
      if (k == 12) begin
        check("np_gap_busy", busy2, 1'b1);
        check("np_done_clear", done2, 1'b0);
      end
    end
    check("np_level", level2, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
